// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding architectural HI/LO
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        rd_hi,
    output logic        busy,
    output logic [31:0] result,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] pend_q, pend_d;
    logic        wr_q, wr_d;

    logic        sgn_m, sgn_d;
    logic [31:0] abs_a, abs_b, quo, rem, quo_s, rem_s;
    logic [63:0] prod, res;

    // Full result of the requested operation; divide works on magnitudes and
    // reapplies signs so the quotient truncates toward zero and the remainder
    // follows the dividend.
    always_comb begin
        sgn_m = op == 3'd0;
        sgn_d = op == 3'd2;
        abs_a = (sgn_d && in_a[31]) ? -in_a : in_a;
        abs_b = (sgn_d && in_b[31]) ? -in_b : in_b;
        quo   = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
        rem   = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
        quo_s = (sgn_d && (in_a[31] ^ in_b[31])) ? -quo : quo;
        rem_s = (sgn_d && in_a[31]) ? -rem : rem;
        prod  = {{32{sgn_m & in_a[31]}}, in_a} * {{32{sgn_m & in_b[31]}}, in_b};
        res   = op[1] ? {rem_s, quo_s} : prod;
    end

    // Next-state: accept work only in IDLE, count down in RUN, commit at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (start && !op[2]) begin
                    pend_d  = res;
                    wr_d    = !(op[1] && in_b == 32'd0);
                    cnt_d   = op[1] ? 16'(DIV_CYCLES) : 16'(MULT_CYCLES);
                    state_d = RUN;
                end else if (start && op == 3'd4) begin
                    hi_d = in_a;
                end else if (start && op == 3'd5) begin
                    lo_d = in_a;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    state_d = IDLE;
                    if (wr_q) {hi_d, lo_d} = pend_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
        end
    end

    assign busy   = state_q == RUN;
    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign result = rd_hi ? hi_q : lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        rd_hi = 1'b0;
    logic        busy;
    logic [31:0] result, hi_out, lo_out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
        .rd_hi(rd_hi), .busy(busy), .result(result), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_hi"}, hi_out, exp_hi);
        check({tag, "_lo"}, lo_out, exp_lo);
        rd_hi = 1'b0;
        #1 check({tag, "_res_lo"}, result, exp_lo);
        rd_hi = 1'b1;
        #1 check({tag, "_res_hi"}, result, exp_hi);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int n_exp, input logic [31:0] h,
                          input logic [31:0] l, input bit poke);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; in_a = a; in_b = b;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            check({tag, "_hold_hi"}, hi_out, exp_hi);
            check({tag, "_hold_lo"}, lo_out, exp_lo);
            if (poke) begin
                start = n < 2;
                op = (n == 0) ? 3'd4 : 3'd2;
                in_a = 32'hDEAD_BEEF;
                in_b = 32'd3;
            end
            @(posedge clk);
            #1 n++;
        end
        start = 1'b0;
        check({tag, "_cycles"}, n, n_exp);
        exp_hi = h;
        exp_lo = l;
        check_regs(tag);
    endtask

    initial begin
        #12 reset = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check_regs("rst");
        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, 0);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("divu0", 3'd3, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, 0);
        run_op("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, 0);
        @(negedge clk);
        start = 1'b1; op = 3'd5; in_a = 32'h1234;
        @(posedge clk);
        #1 start = 1'b0;
        exp_lo = 32'h1234;
        check("mtlo_busy", busy, 0);
        check_regs("mtlo");
        @(negedge clk);
        start = 1'b1; op = 3'd4; in_a = 32'hABCD;
        @(posedge clk);
        #1 start = 1'b0;
        exp_hi = 32'hABCD;
        check("mthi_busy", busy, 0);
        check_regs("mthi");
        @(negedge clk);
        start = 1'b1; op = 3'd6; in_a = 32'h5555;
        @(posedge clk);
        #1 start = 1'b0;
        check("nop_busy", busy, 0);
        check_regs("nop");
        run_op("ignore", 3'd0, 32'h0001_0000, 32'h0001_0000, 5, 32'd1, 32'd0, 1);
        @(negedge clk);
        check("ignore_idle", busy, 0);
        @(negedge clk);
        start = 1'b1; op = 3'd2; in_a = 32'd100; in_b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 exp_hi = '0;
        exp_lo = '0;
        check("arst_busy", busy, 0);
        check_regs("arst");
        @(negedge clk);
        reset = 1'b1;
        run_op("mult56", 3'd0, 32'd5, 32'd6, 5, 32'd0, 32'd30, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit for the E stage of the five-stage pipeline.
- Executes mult/multu/div/divu with fixed multi-cycle latency and holds architectural HI/LO.
- Serves mthi/mtlo writes and mfhi/mflo reads.
- Exports busy so the stall unit can hold dependent md instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset; clears all state when 0
- start  input  1  E-stage md instruction valid this cycle
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
- in_a  input  32  forwarded rs value
- in_b  input  32  forwarded rt value
- rd_hi  input  1  read select: 1 selects HI, 0 selects LO
- busy  output  1  registered; high while an operation is in flight
- result  output  32  combinational: rd_hi ? HI : LO
- hi_out  output  32  current HI register
- lo_out  output  32  current LO register

Behaviour:
- Reset (reset==0, asynchronous): HI=0, LO=0, busy=0, counter=0, pending result cleared, state IDLE. Takes effect immediately, including mid-operation; the in-flight operation is discarded.
- States: IDLE and RUN.
- IDLE, start=1, op in 0..3, sampled at edge T:
  - Latch operands and op; compute the 64-bit pending result into a shadow register.
  - Load counter with the latency N (MULT_CYCLES or DIV_CYCLES); go to RUN.
  - busy=1 from edge T.
- RUN: counter decrements each edge. At the edge where the counter reaches 0: HI/LO <= pending result, busy=0, go to IDLE. busy is therefore high for exactly N cycles. HI/LO are unchanged during RUN.
- mthi/mtlo in IDLE (start=1, op 4/5): HI or LO <= in_a at that edge. No busy, no state change.
- start=1 while busy=1: ignored entirely, including mthi/mtlo and a new mult/div. The stall unit must prevent this; the bench checks it is harmless.
- Operations are back-to-back capable: the start edge immediately following busy falling is accepted.
- Arithmetic:
  - mult: signed 32x32->64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32->64; HI=[63:32], LO=[31:0].
  - div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
  - Divide by zero (in_b==0, div or divu): full DIV_CYCLES busy, then HI and LO keep their prior values.
- result, hi_out and lo_out reflect committed HI/LO only, never the pending value.
- op 6/7 with start=1: no effect.

Test Plan:
- Reset then idle: reset=0 then 1 -> busy=0, hi_out=0, lo_out=0, result=0.
- mult, in_a=0xFFFFFFFE (-2), in_b=3, start for 1 cycle:
  - busy high exactly 5 cycles; HI/LO hold old values meanwhile.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- div, in_a=0xFFFFFFF9 (-7), in_b=2:
  - busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/0 after that -> busy 10 cycles, HI/LO unchanged.
- mtlo in_a=0x1234 in IDLE -> LO=0x1234 next edge, busy stays 0. rd_hi=0 -> result=0x1234.
- During RUN of a mult, pulse start with op=mthi, then op=div -> both ignored; final HI/LO equal the mult result and busy drops on schedule.
- Reset asserted asynchronously (between edges) on the 3rd busy cycle of a div -> busy=0 and HI=LO=0 immediately. After release, a fresh mult (5x6) yields LO=30, HI=0 after 5 cycles.
